// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO read/write controllers:
// default pointer width, depth calculation and Gray code conversions.
package fifo_pkg;

  localparam int unsigned PTR_WIDTH_DEF = 4;
  localparam int unsigned PTR_MAX_W     = 32;

  // Number of storage entries for a pointer that carries one wrap bit
  function automatic int unsigned fifo_depth(input int unsigned ptr_width);
    return 32'd1 << (ptr_width - 32'd1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin_to_gray(input logic [PTR_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray_to_bin(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = int'(PTR_MAX_W) - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Parameterised Gray-to-binary converter: each binary bit is the XOR of
// all Gray bits at or above its position.
module gray2bin #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  for (genvar i = 0; i < int'(W); i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end

endmodule

// File: rtl/fifo_rd.sv
// Read-side controller of the asynchronous FIFO (read clock domain).
// Optional sticky underflow flag enabled by FIFO_RD_UNDERFLOW_CHK_EN.
module fifo_rd
  import fifo_pkg::*;
#(
  parameter int unsigned PTR_WIDTH = PTR_WIDTH_DEF,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic                 r_inc,
  input  logic [PTR_WIDTH-1:0] rq2_wptr,
  output logic [PTR_WIDTH-2:0] r_addr,
  output logic [PTR_WIDTH-1:0] r_ptr,
  output logic                 r_empty,
  output logic [PTR_WIDTH-1:0] r_level,
  output logic                 r_almost_empty,
  output logic                 r_underflow
);

  localparam int unsigned DEPTH = fifo_depth(PTR_WIDTH);

  if (AE_THRESH > DEPTH) begin : g_bad_thresh
    $error("fifo_rd: AE_THRESH exceeds FIFO depth");
  end

  logic [PTR_WIDTH-1:0] rbin_q, rbin_d;
  logic [PTR_WIDTH-1:0] rgray_q, rgray_d;
  logic [PTR_WIDTH-1:0] level_q, level_d;
  logic                 empty_q, empty_d;
  logic                 ae_q, ae_d;
  logic [PTR_WIDTH-1:0] wbin_s;
  logic                 rd_en;

  gray2bin #(.W(PTR_WIDTH)) u_wptr_g2b (
    .gray_i (rq2_wptr),
    .bin_o  (wbin_s)
  );

  // Pointer advance and status computed from the post-pop pointer
  always_comb begin
    rd_en   = r_inc & ~empty_q;
    rbin_d  = rbin_q + PTR_WIDTH'(rd_en);
    rgray_d = PTR_WIDTH'(bin_to_gray(PTR_MAX_W'(rbin_d)));
    level_d = wbin_s - rbin_d;
    empty_d = (rgray_d == rq2_wptr);
    ae_d    = (level_d <= PTR_WIDTH'(AE_THRESH));
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      rbin_q  <= '0;
      rgray_q <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
    end else begin
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      level_q <= level_d;
      empty_q <= empty_d;
      ae_q    <= ae_d;
    end
  end

  assign r_addr         = rbin_q[PTR_WIDTH-2:0];
  assign r_ptr          = rgray_q;
  assign r_empty        = empty_q;
  assign r_level        = level_q;
  assign r_almost_empty = ae_q;

`ifdef FIFO_RD_UNDERFLOW_CHK_EN
  logic underflow_q, underflow_d;

  // Sticky: any pop attempted while empty, cleared only by reset
  always_comb begin
    underflow_d = underflow_q | (r_inc & empty_q);
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
    end
  end

  assign r_underflow = underflow_q;
`else
  assign r_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd.sv
// Self-checking bench for fifo_rd (PTR_WIDTH=4, depth 8, AE_THRESH=2):
// directed scenarios plus randomized traffic against an occupancy model.
module tb_fifo_rd;

`ifdef FIFO_RD_UNDERFLOW_CHK_EN
  localparam bit UF_EN = 1'b1;
`else
  localparam bit UF_EN = 1'b0;
`endif

  logic       r_clk = 1'b0;
  logic       r_rst = 1'b1;
  logic       r_inc = 1'b0;
  logic [3:0] rq2_wptr = 4'b0000;
  logic [2:0] r_addr;
  logic [3:0] r_ptr;
  logic       r_empty;
  logic [3:0] r_level;
  logic       r_almost_empty;
  logic       r_underflow;

  int total = 0;
  int bad   = 0;

  // Model: entries read so far, entries written so far (mod 16), occupancy
  int m_rbin  = 0;
  int m_wb    = 0;
  int m_level = 0;
  bit m_uf    = 1'b0;

  fifo_rd #(.PTR_WIDTH(4), .AE_THRESH(2)) dut (
    .r_clk          (r_clk),
    .r_rst          (r_rst),
    .r_inc          (r_inc),
    .rq2_wptr       (rq2_wptr),
    .r_addr         (r_addr),
    .r_ptr          (r_ptr),
    .r_empty        (r_empty),
    .r_level        (r_level),
    .r_almost_empty (r_almost_empty),
    .r_underflow    (r_underflow)
  );

  always #5 r_clk = ~r_clk;

  function automatic logic [3:0] gray4(input int b);
    logic [3:0] x;
    x = 4'(b);
    return x ^ (x >> 1);
  endfunction

  // Drive one cycle and advance the occupancy model; outputs sampled 1ns after the edge
  task automatic step(input bit rst, input bit inc, input int wb);
    r_rst    = rst;
    r_inc    = inc;
    rq2_wptr = gray4(wb);
    @(posedge r_clk);
    #1;
    if (rst) begin
      m_rbin = 0;
      m_uf   = 1'b0;
      m_level = 0;
    end else begin
      if (inc && m_level == 0) begin
        if (UF_EN) m_uf = 1'b1;
      end else if (inc) begin
        m_rbin = (m_rbin + 1) % 16;
      end
      m_level = (wb - m_rbin + 16) % 16;
    end
    m_wb = wb;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 0);
      total++;
      if (r_ptr !== 4'b0000 || r_addr !== 3'd0 || r_empty !== 1'b1 ||
          r_level !== 4'd0 || r_almost_empty !== 1'b1 || r_underflow !== 1'b0) begin
        bad++;
        $display("FAIL reset[%0d]: ptr=%b addr=%0d empty=%b level=%0d ae=%b uf=%b want 0000/0/1/0/1/0",
                 i, r_ptr, r_addr, r_empty, r_level, r_almost_empty, r_underflow);
      end
    end
  endtask

  task automatic test_fill();
    step(1'b0, 1'b0, 3);
    total++;
    if (r_empty !== 1'b0 || r_level !== 4'd3 || r_almost_empty !== 1'b0) begin
      bad++;
      $display("FAIL fill: empty=%b level=%0d ae=%b want 0/3/0", r_empty, r_level, r_almost_empty);
    end
  endtask

  task automatic test_drain();
    logic [3:0] exp_ptr [3];
    exp_ptr = '{4'b0001, 4'b0011, 4'b0010};
    for (int i = 0; i < 3; i++) begin
      total++;
      if (r_addr !== 3'(i)) begin
        bad++;
        $display("FAIL drain_addr[%0d]: got %0d want %0d", i, r_addr, i);
      end
      step(1'b0, 1'b1, 3);
      total++;
      if (r_ptr !== exp_ptr[i] || r_level !== 4'(2 - i) || r_almost_empty !== 1'b1 ||
          r_empty !== (i == 2)) begin
        bad++;
        $display("FAIL drain[%0d]: ptr=%b level=%0d ae=%b empty=%b want %b/%0d/1/%0b",
                 i, r_ptr, r_level, r_almost_empty, r_empty, exp_ptr[i], 2 - i, i == 2);
      end
    end
    step(1'b0, 1'b1, 3);
    total++;
    if (r_ptr !== 4'b0010 || r_empty !== 1'b1 || r_addr !== 3'd3) begin
      bad++;
      $display("FAIL drain_extra: ptr=%b empty=%b addr=%0d want 0010/1/3", r_ptr, r_empty, r_addr);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 8);
    total++;
    if (r_level !== 4'd8 || r_empty !== 1'b0) begin
      bad++;
      $display("FAIL wrap_full: level=%0d empty=%b want 8/0", r_level, r_empty);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (r_addr !== 3'(i)) begin
        bad++;
        $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, r_addr, i);
      end
      step(1'b0, 1'b1, 8);
    end
    total++;
    if (r_addr !== 3'd0 || r_ptr !== 4'b1100 || r_empty !== 1'b1 || r_level !== 4'd0) begin
      bad++;
      $display("FAIL wrap_end: addr=%0d ptr=%b empty=%b level=%0d want 0/1100/1/0",
               r_addr, r_ptr, r_empty, r_level);
    end
    step(1'b0, 1'b0, 9);
    total++;
    if (r_empty !== 1'b0 || r_level !== 4'd1) begin
      bad++;
      $display("FAIL wrap_refill: empty=%b level=%0d want 0/1", r_empty, r_level);
    end
  endtask

  task automatic test_underflow();
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 0);
    total++;
    if (r_underflow !== UF_EN || r_ptr !== 4'b0000 || r_empty !== 1'b1) begin
      bad++;
      $display("FAIL underflow_set: uf=%b ptr=%b empty=%b want %b/0000/1", r_underflow, r_ptr, r_empty, UF_EN);
    end
    step(1'b0, 1'b0, 1);
    step(1'b0, 1'b1, 1);
    total++;
    if (r_underflow !== UF_EN || r_ptr !== 4'b0001 || r_empty !== 1'b1) begin
      bad++;
      $display("FAIL underflow_sticky: uf=%b ptr=%b empty=%b want %b/0001/1", r_underflow, r_ptr, r_empty, UF_EN);
    end
    step(1'b1, 1'b0, 0);
    total++;
    if (r_underflow !== 1'b0) begin
      bad++;
      $display("FAIL underflow_clear: uf=%b want 0", r_underflow);
    end
  endtask

  task automatic test_reset_mid_drain();
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 3);
    step(1'b0, 1'b1, 3);
    step(1'b0, 1'b1, 3);
    step(1'b1, 1'b1, 3);
    total++;
    if (r_ptr !== 4'b0000 || r_addr !== 3'd0 || r_empty !== 1'b1 || r_level !== 4'd0) begin
      bad++;
      $display("FAIL mid_reset: ptr=%b addr=%0d empty=%b level=%0d want 0000/0/1/0",
               r_ptr, r_addr, r_empty, r_level);
    end
    step(1'b0, 1'b0, 3);
    total++;
    if (r_empty !== 1'b0 || r_level !== 4'd3) begin
      bad++;
      $display("FAIL mid_reset_release: empty=%b level=%0d want 0/3", r_empty, r_level);
    end
  endtask

  task automatic test_random();
    int wb;
    bit rst, inc;
    step(1'b1, 1'b0, 0);
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      inc = ($urandom_range(0, 99) < 55);
      wb  = m_wb;
      if (rst) wb = 0;
      else if ($urandom_range(0, 99) < 50 && ((m_wb - m_rbin + 16) % 16) < 8) wb = (m_wb + 1) % 16;
      step(rst, inc, wb);
      total++;
      if (r_addr !== 3'(m_rbin % 8) || r_ptr !== gray4(m_rbin) || r_level !== 4'(m_level) ||
          r_empty !== (m_level == 0) || r_almost_empty !== (m_level <= 2) || r_underflow !== m_uf) begin
        bad++;
        $display("FAIL random[%0d]: addr=%0d ptr=%b lvl=%0d e=%b ae=%b uf=%b want %0d/%b/%0d/%0b/%0b/%b",
                 n, r_addr, r_ptr, r_level, r_empty, r_almost_empty, r_underflow,
                 m_rbin % 8, gray4(m_rbin), m_level, m_level == 0, m_level <= 2, m_uf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_underflow();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_rd.md
Name: fifo_rd

Overview:
Read-side control for the team's asynchronous FIFO, in the read clock domain, downstream of the write-side controller. It owns the read pointer and drives the read address into the dual-port memory. It exports the Gray-coded read pointer to the write-domain synchroniser. It compares that pointer against the already-synchronised write pointer to produce empty, fill-level and almost-empty status.

Parameters:
PTR_WIDTH, 4, pointer width including wrap bit; FIFO depth = 2^(PTR_WIDTH-1)
AE_THRESH, 2, almost-empty threshold in entries (0..depth)

Ports:
r_clk  input  1  read-domain clock
r_rst  input  1  synchronous, active-high reset
r_inc  input  1  read request (pop) for this cycle
rq2_wptr  input  PTR_WIDTH  Gray write pointer, already 2-flop synchronised into r_clk
r_addr  output  PTR_WIDTH-1  memory read address
r_ptr  output  PTR_WIDTH  registered Gray read pointer, sent to write-domain synchroniser
r_empty  output  1  FIFO empty, registered
r_level  output  PTR_WIDTH  entries available as seen by read side (0..depth), registered
r_almost_empty  output  1  r_level <= AE_THRESH, registered
r_underflow  output  1  sticky underflow error (see Optional Feature)

Behaviour:
- Clock and reset: one clock, r_clk. Reset is synchronous and active-high on r_rst. All state updates occur only on the r_clk rising edge.
- Reset values: rbin=0, r_ptr=0, r_empty=1, r_level=0, r_almost_empty=1, r_underflow=0.
- Reset behaviour: reset takes priority over r_inc in the same cycle. Reset mid-operation discards all read progress immediately.
- Read qualification: rd_en = r_inc & ~r_empty. When r_inc=1 and r_empty=1 the pop is ignored and all pointers hold.
- Next pointer values: rbin_next = rbin + rd_en, modulo 2^PTR_WIDTH. rgray_next = (rbin_next >> 1) ^ rbin_next.
- r_addr = rbin[PTR_WIDTH-2:0], taken combinationally from the register. Zero latency to memory, so the data at r_addr is the current head.
- r_ptr is updated to rgray_next every cycle, giving 1-cycle latency after an accepted pop.
- r_empty <= (rgray_next == rq2_wptr). It asserts on the same edge that consumes the last entry, so there is no extra read-after-empty window.
- Level: wbin_s = gray-to-binary(rq2_wptr). r_level <= (wbin_s - rbin_next), modulo 2^PTR_WIDTH, and is never greater than depth.
- r_almost_empty <= (level_next <= AE_THRESH).
- Wrap-around: the MSB of rbin toggles every depth reads. r_addr wraps from depth-1 to 0. Empty requires all PTR_WIDTH Gray bits equal, MSB included.
- Status is pessimistic: the synchronised write pointer lags by 2 write-domain cycles, so r_empty and r_level may under-report but never over-report.
- Simultaneous pop and rq2_wptr change in one cycle: both are folded into the same edge's computation.

Optional Feature:
FIFO_RD_UNDERFLOW_CHK_EN
- Defined: r_underflow sets on any edge where r_inc=1 and r_empty=1. It stays set until r_rst.
- Undefined: r_underflow is tied to 0 and no register is inferred.
- In both cases pointer behaviour is identical; the ignored pop never moves the pointer.

Decomposition:
- Shared package fifo_pkg holds:
  - default PTR_WIDTH;
  - a DEPTH constant function;
  - bin-to-Gray and Gray-to-binary functions, also reused by the write-side controller.
- One sub-module, gray2bin: parameterised prefix-XOR converter, instantiated on rq2_wptr.

Test Plan (PTR_WIDTH=4, depth 8, AE_THRESH=2):
- Reset: hold r_rst=1 for 2 cycles with r_inc=1 -> r_ptr=0000, r_addr=0, r_empty=1, r_level=0, r_almost_empty=1.
- Fill visibility: rq2_wptr=0010 (bin 3), r_inc=0 -> one edge later r_empty=0, r_level=3, r_almost_empty=0.
- Drain: keep rq2_wptr=0010 and pulse r_inc for 3 cycles.
  - r_addr goes 0,1,2.
  - r_ptr goes 0001, 0011, 0010.
  - r_level goes 2, 1, 0.
  - r_almost_empty=1 after the first pop.
  - r_empty=1 on the third edge.
  - A fourth r_inc leaves r_ptr=0010.
- Wrap: rq2_wptr=1100 (bin 8) from reset, then 8 pops -> r_addr 0..7 then 0, r_ptr=1100, r_empty=1. Then rq2_wptr=1101 (bin 9) -> r_empty=0, r_level=1.
- Underflow (macro defined): r_inc=1 while empty -> r_underflow=1 next edge and stays 1 after later valid pops. With the macro undefined it stays 0.
- Reset mid-drain: assert r_rst after 2 of 3 pops -> next edge r_ptr=0000, r_addr=0, r_empty=1 regardless of r_inc. Once r_rst is released, r_empty=0 and r_level=3 next edge while rq2_wptr=0010.
